// File: rtl/single_port_ram_pkg.sv
// Shared defaults and the access classification used by the single-port RAM.
package single_port_ram_pkg;

  localparam int DEF_ADDR_WIDTH = 5;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MEM_DEPTH  = 32;

  typedef enum logic [1:0] {
    ACC_IDLE,
    ACC_WRITE,
    ACC_READ,
    ACC_RANGE_ERR
  } access_e;

endpackage

// File: rtl/single_port_ram_if.sv
// Request/response bundle for the single-port RAM; master drives requests, slave answers.
interface single_port_ram_if
  import single_port_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
);

  logic                  en;
  logic                  wr_rd;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] din;
  logic                  valid;
  logic [DATA_WIDTH-1:0] dout;
  logic                  ready;
  logic                  error;

  modport master (
    output en, wr_rd, addr, din, valid,
    input  dout, ready, error
  );

  modport slave (
    input  en, wr_rd, addr, din, valid,
    output dout, ready, error
  );

endinterface

// File: rtl/single_port_ram.sv
// Single-port synchronous RAM with registered read data, ready pulse and out-of-range error flag.
// The storage array is deliberately left out of reset so contents survive a reset pulse.
module single_port_ram
  import single_port_ram_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_DEPTH  = DEF_MEM_DEPTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  single_port_ram_if.slave      bus
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LP_DEPTH = (ADDR_WIDTH+1)'(MEM_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  r_ready;
  logic                  r_error;

  logic                  w_in_range;
  logic [IDX_W-1:0]      w_idx;
  access_e               w_acc;

  assign w_in_range = ({1'b0, bus.addr} < LP_DEPTH);
  assign w_idx      = bus.addr[IDX_W-1:0];

  always_comb begin
    w_acc = ACC_IDLE;
    if (bus.en && bus.valid) begin
      if (!w_in_range)     w_acc = ACC_RANGE_ERR;
      else if (bus.wr_rd)  w_acc = ACC_WRITE;
      else                 w_acc = ACC_READ;
    end
  end

  // No reset on the array; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rstn && (w_acc == ACC_WRITE)) begin
      r_mem[w_idx] <= bus.din;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_dout  <= '0;
      r_ready <= 1'b0;
      r_error <= 1'b0;
    end else begin
      r_ready <= (w_acc != ACC_IDLE);
      r_error <= (w_acc == ACC_RANGE_ERR);
      case (w_acc)
        ACC_READ:      r_dout <= r_mem[w_idx];
        ACC_RANGE_ERR: if (!bus.wr_rd) r_dout <= '0;
        default:       r_dout <= r_dout;
      endcase
    end
  end

  assign bus.dout  = r_dout;
  assign bus.ready = r_ready;
  assign bus.error = r_error;

endmodule

// File: tb/tb_single_port_ram.sv
// Directed, table-driven check of single_port_ram (MEM_DEPTH=16 in a 5-bit address space).
module tb_single_port_ram;

  logic clk;
  logic rstn;

  int n_checks;
  int n_fail;

  single_port_ram_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32)) bus ();

  single_port_ram #(
    .ADDR_WIDTH(5),
    .DATA_WIDTH(32),
    .MEM_DEPTH (16)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        en;
    logic        valid;
    logic        wr_rd;
    logic [4:0]  addr;
    logic [31:0] din;
    logic [31:0] exp_dout;
    logic        exp_ready;
    logic        exp_error;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic en, logic valid, logic wr_rd,
                              logic [4:0] addr, logic [31:0] din,
                              logic [31:0] exp_dout, logic exp_ready, logic exp_error);
    vec_t v;
    v.name = name; v.en = en; v.valid = valid; v.wr_rd = wr_rd;
    v.addr = addr; v.din = din; v.exp_dout = exp_dout;
    v.exp_ready = exp_ready; v.exp_error = exp_error;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(logic en, logic valid, logic wr_rd, logic [4:0] addr, logic [31:0] din);
    bus.en = en; bus.valid = valid; bus.wr_rd = wr_rd; bus.addr = addr; bus.din = din;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(string name, logic [31:0] d, logic r, logic e);
    chk({name, ".dout"},  bus.dout,         d);
    chk({name, ".ready"}, 32'(bus.ready),   32'(r));
    chk({name, ".error"}, 32'(bus.error),   32'(e));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Each vector is one edge; expected values describe outputs just after that edge.
    vecs.push_back(mk("wr3",      1, 1, 1,  3, 32'h3A3A3A3A, 32'h2A2A2A2A, 1, 0));
    vecs.push_back(mk("idle_en0", 0, 1, 0,  3, 32'h0,        32'h2A2A2A2A, 0, 0));
    vecs.push_back(mk("rd3",      1, 1, 0,  3, 32'h0,        32'h3A3A3A3A, 1, 0));
    vecs.push_back(mk("wr4",      1, 1, 1,  4, 32'h4A4A4A4A, 32'h3A3A3A3A, 1, 0));
    vecs.push_back(mk("wr5",      1, 1, 1,  5, 32'h4B4B4B4B, 32'h3A3A3A3A, 1, 0));
    vecs.push_back(mk("rd4",      1, 1, 0,  4, 32'h0,        32'h4A4A4A4A, 1, 0));
    vecs.push_back(mk("rd5",      1, 1, 0,  5, 32'h0,        32'h4B4B4B4B, 1, 0));
    vecs.push_back(mk("wr8a",     1, 1, 1,  8, 32'h6A6A6A6A, 32'h4B4B4B4B, 1, 0));
    vecs.push_back(mk("rd8a",     1, 1, 0,  8, 32'h0,        32'h6A6A6A6A, 1, 0));
    vecs.push_back(mk("wr8b",     1, 1, 1,  8, 32'h6B6B6B6B, 32'h6A6A6A6A, 1, 0));
    vecs.push_back(mk("rd8b",     1, 1, 0,  8, 32'h0,        32'h6B6B6B6B, 1, 0));
    vecs.push_back(mk("wr15",     1, 1, 1, 15, 32'h0F0F0F0F, 32'h6B6B6B6B, 1, 0));
    vecs.push_back(mk("wr31_oor", 1, 1, 1, 31, 32'h7A7A7A7A, 32'h6B6B6B6B, 1, 1));
    vecs.push_back(mk("idle_err", 0, 0, 0,  0, 32'h0,        32'h6B6B6B6B, 0, 0));
    vecs.push_back(mk("rd15",     1, 1, 0, 15, 32'h0,        32'h0F0F0F0F, 1, 0));
    vecs.push_back(mk("wr16_oor", 1, 1, 1, 16, 32'h11111111, 32'h0F0F0F0F, 1, 1));
    vecs.push_back(mk("rd0_ok",   1, 1, 0,  0, 32'h0,        32'h2A2A2A2A, 1, 0));
    vecs.push_back(mk("rd16_oor", 1, 1, 0, 16, 32'h0,        32'h00000000, 1, 1));
    vecs.push_back(mk("rd15b",    1, 1, 0, 15, 32'h0,        32'h0F0F0F0F, 1, 0));
    vecs.push_back(mk("gate_en",  0, 1, 1, 15, 32'hDEADBEEF, 32'h0F0F0F0F, 0, 0));
    vecs.push_back(mk("gate_vld", 1, 0, 1, 15, 32'hCAFEF00D, 32'h0F0F0F0F, 0, 0));
    vecs.push_back(mk("rd15c",    1, 1, 0, 15, 32'h0,        32'h0F0F0F0F, 1, 0));
    vecs.push_back(mk("rd31_oor", 1, 1, 0, 31, 32'h0,        32'h00000000, 1, 1));
    vecs.push_back(mk("rd2",      1, 1, 0,  2, 32'h0,        32'h2A2A2A2A, 1, 0));

    // Power-on reset
    rstn = 1'b0;
    drive(0, 0, 0, 0, 32'h0);
    #3;
    chk_outs("por", 32'h0, 1'b0, 1'b0);
    step();
    step();
    @(negedge clk);
    rstn = 1'b1;

    // Write addr 2 and addr 0, read addr 2 back so dout is non-zero before reset
    drive(1, 1, 1, 2, 32'h2A2A2A2A);
    step();
    chk_outs("wr2", 32'h0, 1'b1, 1'b0);
    drive(1, 1, 1, 0, 32'h2A2A2A2A);
    step();
    drive(1, 1, 0, 2, 32'h0);
    step();
    chk_outs("rd2_pre", 32'h2A2A2A2A, 1'b1, 1'b0);

    // Asynchronous reset between edges clears outputs at once, not the array
    #2;
    rstn = 1'b0;
    #1;
    chk_outs("rst_async", 32'h0, 1'b0, 1'b0);
    drive(0, 0, 0, 0, 32'h0);
    @(posedge clk);
    #1;
    chk_outs("rst_held", 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    rstn = 1'b1;

    // First edge after release accepts a read; data survived reset
    drive(1, 1, 0, 2, 32'h0);
    step();
    chk_outs("rd2_post", 32'h2A2A2A2A, 1'b1, 1'b0);

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].valid, vecs[i].wr_rd, vecs[i].addr, vecs[i].din);
      step();
      chk_outs(vecs[i].name, vecs[i].exp_dout, vecs[i].exp_ready, vecs[i].exp_error);
    end

    // Back-to-back requests keep ready high; error asserts only on the out-of-range cycle
    drive(1, 1, 0, 4, 32'h0);
    step();
    chk_outs("b2b_rd4", 32'h4A4A4A4A, 1'b1, 1'b0);
    drive(1, 1, 1, 20, 32'h55555555);
    step();
    chk_outs("b2b_wr20", 32'h4A4A4A4A, 1'b1, 1'b1);
    drive(1, 1, 0, 4, 32'h0);
    step();
    chk_outs("b2b_rd4b", 32'h4A4A4A4A, 1'b1, 1'b0);
    drive(0, 0, 0, 0, 32'h0);
    step();
    chk_outs("b2b_idle", 32'h4A4A4A4A, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
